// File: rtl/branch_target_unit.sv
// Registered branch/jump resolution stage with condition evaluation,
// misaligned-JR detection and a wrong-path squash window.
module branch_target_unit #(
    parameter int PC_WIDTH      = 32,
    parameter int IMM_WIDTH     = 16,
    parameter int JUMP_WIDTH    = 26,
    parameter int DATA_WIDTH    = 32,
    parameter int SQUASH_CYCLES = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  InValid,
    input  logic                  Stall,
    input  logic [2:0]            Mode,
    input  logic [PC_WIDTH-1:0]   PCNext,
    input  logic [IMM_WIDTH-1:0]  Imm,
    input  logic [JUMP_WIDTH-1:0] JumpField,
    input  logic [DATA_WIDTH-1:0] RegA,
    input  logic [DATA_WIDTH-1:0] RegB,
    output logic                  OutValid,
    output logic                  Taken,
    output logic [PC_WIDTH-1:0]   Target,
    output logic                  Redirect,
    output logic                  Squash,
    output logic                  AddrErr
);

    typedef enum logic [2:0] {
        M_NONE = 3'b000,
        M_BEQ  = 3'b001,
        M_BNE  = 3'b010,
        M_BLEZ = 3'b011,
        M_BGTZ = 3'b100,
        M_BLTZ = 3'b101,
        M_J    = 3'b110,
        M_JR   = 3'b111
    } mode_e;

    mode_e mode;
    logic  accept;
    logic  cond;
    logic  misalign;
    logic  is_jr;

    logic signed [DATA_WIDTH-1:0] reg_a_s;
    logic [PC_WIDTH-1:0]          imm_off;
    logic [PC_WIDTH-1:0]          br_tgt;
    logic [PC_WIDTH-1:0]          j_tgt;
    logic [PC_WIDTH-1:0]          jr_tgt;
    logic [PC_WIDTH-1:0]          res_tgt;

    logic                out_valid_q, out_valid_d;
    logic                taken_q, taken_d;
    logic [PC_WIDTH-1:0] target_q, target_d;
    logic                redirect_q, redirect_d;
    logic                addr_err_q, addr_err_d;
    logic [3:0]          cnt_q, cnt_d;

    assign mode    = mode_e'(Mode);
    assign accept  = InValid & ~Stall;
    assign reg_a_s = $signed(RegA);

    always_comb begin
        imm_off = PC_WIDTH'($signed(Imm)) << 2;
        br_tgt  = PCNext + imm_off;
        // Upper PCNext bits survive only when the jump field leaves room.
        j_tgt   = PCNext;
        j_tgt[JUMP_WIDTH+1:0] = {JumpField, 2'b00};
        jr_tgt  = PC_WIDTH'(RegA);
    end

    always_comb begin
        cond    = 1'b0;
        res_tgt = br_tgt;
        is_jr   = 1'b0;
        unique case (mode)
            M_NONE: res_tgt = PCNext;
            M_BEQ:  cond = (RegA == RegB);
            M_BNE:  cond = (RegA != RegB);
            M_BLEZ: cond = (reg_a_s <= 0);
            M_BGTZ: cond = (reg_a_s > 0);
            M_BLTZ: cond = (reg_a_s < 0);
            M_J: begin
                cond    = 1'b1;
                res_tgt = j_tgt;
            end
            M_JR: begin
                cond    = 1'b1;
                res_tgt = jr_tgt;
                is_jr   = 1'b1;
            end
        endcase
        misalign = is_jr & (RegA[1:0] != 2'b00);
    end

    always_comb begin
        out_valid_d = 1'b0;
        taken_d     = 1'b0;
        target_d    = target_q;
        redirect_d  = 1'b0;
        addr_err_d  = 1'b0;
        cnt_d       = cnt_q;
        if (Stall) begin
            out_valid_d = out_valid_q;
            taken_d     = taken_q;
        end else if (accept) begin
            if (cnt_q != 4'd0) begin
                // Wrong-path slot: killed, and it may not reload the window.
                cnt_d = cnt_q - 4'd1;
            end else begin
                out_valid_d = 1'b1;
                target_d    = res_tgt;
                taken_d     = cond & ~misalign;
                addr_err_d  = misalign;
                redirect_d  = cond & ~misalign;
                if (cond & ~misalign) begin
                    cnt_d = 4'(SQUASH_CYCLES);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            redirect_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            out_valid_q <= out_valid_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            redirect_q  <= redirect_d;
            addr_err_q  <= addr_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign OutValid = out_valid_q;
    assign Taken    = taken_q;
    assign Target   = target_q;
    assign Redirect = redirect_q;
    assign AddrErr  = addr_err_q;
    assign Squash   = (cnt_q != 4'd0);

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit: a SQUASH_CYCLES=1 instance plus
// a SQUASH_CYCLES=0 instance sharing the same stimulus.
module tb_branch_target_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        InValid;
    logic        Stall;
    logic [2:0]  Mode;
    logic [31:0] PCNext;
    logic [15:0] Imm;
    logic [25:0] JumpField;
    logic [31:0] RegA;
    logic [31:0] RegB;

    logic        OutValid, Taken, Redirect, Squash, AddrErr;
    logic [31:0] Target;
    logic        z_OutValid, z_Taken, z_Redirect, z_Squash, z_AddrErr;
    logic [31:0] z_Target;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    branch_target_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .Stall(Stall),
        .Mode(Mode), .PCNext(PCNext), .Imm(Imm), .JumpField(JumpField),
        .RegA(RegA), .RegB(RegB), .OutValid(OutValid), .Taken(Taken),
        .Target(Target), .Redirect(Redirect), .Squash(Squash),
        .AddrErr(AddrErr)
    );

    branch_target_unit #(.SQUASH_CYCLES(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .Stall(Stall),
        .Mode(Mode), .PCNext(PCNext), .Imm(Imm), .JumpField(JumpField),
        .RegA(RegA), .RegB(RegB), .OutValid(z_OutValid), .Taken(z_Taken),
        .Target(z_Target), .Redirect(z_Redirect), .Squash(z_Squash),
        .AddrErr(z_AddrErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] m, input logic [31:0] pc,
                         input logic [15:0] im, input logic [25:0] jf,
                         input logic [31:0] a, input logic [31:0] b);
        InValid = 1'b1;
        Stall = 1'b0;
        Mode = m;
        PCNext = pc;
        Imm = im;
        JumpField = jf;
        RegA = a;
        RegB = b;
    endtask

    task automatic idle();
        InValid = 1'b0;
        Stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n = 1'b0;
        idle();
        Mode = 3'b000;
        PCNext = '0;
        Imm = '0;
        JumpField = '0;
        RegA = '0;
        RegB = '0;
        #3;
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_target", Target, 32'd0);
        chk("rst_squash", {31'd0, Squash}, 32'd0);
        #12;
        Rst_n = 1'b1;
        tick();

        // Load the squash window, then reset asynchronously mid-cycle.
        issue(3'b001, 32'h100, 16'hFFFF, 26'd0, 32'd5, 32'd5);
        tick();
        chk("pre_rst_squash", {31'd0, Squash}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_squash", {31'd0, Squash}, 32'd0);
        chk("mid_rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("mid_rst_redirect", {31'd0, Redirect}, 32'd0);
        chk("mid_rst_taken", {31'd0, Taken}, 32'd0);
        chk("mid_rst_target", Target, 32'd0);
        #1;
        Rst_n = 1'b1;

        issue(3'b001, 32'h100, 16'hFFFF, 26'd0, 32'd5, 32'd5);
        tick();
        chk("beq_outvalid", {31'd0, OutValid}, 32'd1);
        chk("beq_taken", {31'd0, Taken}, 32'd1);
        chk("beq_target", Target, 32'h0000_00FC);
        chk("beq_redirect", {31'd0, Redirect}, 32'd1);
        chk("beq_squash", {31'd0, Squash}, 32'd1);

        issue(3'b000, 32'h104, 16'd0, 26'd0, 32'd0, 32'd0);
        tick();
        chk("kill_outvalid", {31'd0, OutValid}, 32'd0);
        chk("kill_squash", {31'd0, Squash}, 32'd0);
        chk("kill_redirect", {31'd0, Redirect}, 32'd0);

        issue(3'b010, 32'hFFFF_FFFC, 16'h0001, 26'd0, 32'd1, 32'd2);
        tick();
        chk("bne_wrap_target", Target, 32'h0);
        chk("bne_taken", {31'd0, Taken}, 32'd1);
        chk("bne_redirect", {31'd0, Redirect}, 32'd1);
        issue(3'b000, 32'h0, 16'd0, 26'd0, 32'd0, 32'd0);
        tick();
        issue(3'b010, 32'hFFFF_FFFC, 16'h0001, 26'd0, 32'd3, 32'd3);
        tick();
        chk("bne_nt_taken", {31'd0, Taken}, 32'd0);
        chk("bne_nt_redirect", {31'd0, Redirect}, 32'd0);
        chk("bne_nt_squash", {31'd0, Squash}, 32'd0);
        chk("bne_nt_outvalid", {31'd0, OutValid}, 32'd1);
        chk("bne_nt_target", Target, 32'h0);

        issue(3'b110, 32'h4000_0008, 16'd0, 26'h0000010, 32'd0, 32'd0);
        tick();
        chk("j_target", Target, 32'h4000_0040);
        chk("j_taken", {31'd0, Taken}, 32'd1);
        issue(3'b000, 32'h0, 16'd0, 26'd0, 32'd0, 32'd0);
        tick();
        issue(3'b101, 32'h1000, 16'h0002, 26'd0, 32'h8000_0000, 32'd0);
        tick();
        chk("bltz_taken", {31'd0, Taken}, 32'd1);
        chk("bltz_target", Target, 32'h1008);
        issue(3'b000, 32'h0, 16'd0, 26'd0, 32'd0, 32'd0);
        tick();
        issue(3'b100, 32'h1000, 16'h0002, 26'd0, 32'd0, 32'd0);
        tick();
        chk("bgtz0_taken", {31'd0, Taken}, 32'd0);
        chk("bgtz0_outvalid", {31'd0, OutValid}, 32'd1);
        issue(3'b011, 32'h2000, 16'hFFFE, 26'd0, 32'd0, 32'd0);
        tick();
        chk("blez0_taken", {31'd0, Taken}, 32'd1);
        chk("blez0_target", Target, 32'h1FF8);
        issue(3'b000, 32'h0, 16'd0, 26'd0, 32'd0, 32'd0);
        tick();

        issue(3'b111, 32'h0, 16'd0, 26'd0, 32'h1002, 32'd0);
        tick();
        chk("jr_mis_addrerr", {31'd0, AddrErr}, 32'd1);
        chk("jr_mis_redirect", {31'd0, Redirect}, 32'd0);
        chk("jr_mis_taken", {31'd0, Taken}, 32'd0);
        chk("jr_mis_outvalid", {31'd0, OutValid}, 32'd1);
        chk("jr_mis_target", Target, 32'h1002);
        chk("jr_mis_squash", {31'd0, Squash}, 32'd0);
        idle();
        tick();
        chk("idle_addrerr", {31'd0, AddrErr}, 32'd0);
        chk("idle_outvalid", {31'd0, OutValid}, 32'd0);
        chk("idle_target_hold", Target, 32'h1002);
        issue(3'b111, 32'h0, 16'd0, 26'd0, 32'h1000, 32'd0);
        tick();
        chk("jr_target", Target, 32'h1000);
        chk("jr_redirect", {31'd0, Redirect}, 32'd1);
        issue(3'b000, 32'h0, 16'd0, 26'd0, 32'd0, 32'd0);
        tick();
        issue(3'b000, 32'h500, 16'd0, 26'd0, 32'd0, 32'd0);
        tick();
        chk("none_outvalid", {31'd0, OutValid}, 32'd1);
        chk("none_taken", {31'd0, Taken}, 32'd0);
        chk("none_target", Target, 32'h500);

        issue(3'b001, 32'h200, 16'h0004, 26'd0, 32'd7, 32'd7);
        tick();
        chk("stl_redirect0", {31'd0, Redirect}, 32'd1);
        issue(3'b110, 32'h0, 16'd0, 26'h3FF, 32'd0, 32'd0);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_redirect", {31'd0, Redirect}, 32'd0);
            chk("stl_outvalid", {31'd0, OutValid}, 32'd1);
            chk("stl_taken", {31'd0, Taken}, 32'd1);
            chk("stl_target", Target, 32'h210);
            chk("stl_squash", {31'd0, Squash}, 32'd1);
        end
        issue(3'b001, 32'h600, 16'h0000, 26'd0, 32'd1, 32'd1);
        tick();
        chk("post_stl_outvalid", {31'd0, OutValid}, 32'd0);
        chk("post_stl_redirect", {31'd0, Redirect}, 32'd0);
        chk("post_stl_squash", {31'd0, Squash}, 32'd0);
        idle();
        tick();
        chk("post_idle_taken", {31'd0, Taken}, 32'd0);

        issue(3'b001, 32'h300, 16'h0001, 26'd0, 32'd9, 32'd9);
        tick();
        chk("b2b0_redirect_a", {31'd0, z_Redirect}, 32'd1);
        chk("b2b0_target_a", z_Target, 32'h304);
        chk("b2b1_redirect_a", {31'd0, Redirect}, 32'd1);
        issue(3'b001, 32'h400, 16'h0000, 26'd0, 32'd9, 32'd9);
        tick();
        chk("b2b0_redirect_b", {31'd0, z_Redirect}, 32'd1);
        chk("b2b0_target_b", z_Target, 32'h400);
        chk("b2b0_squash", {31'd0, z_Squash}, 32'd0);
        chk("b2b1_redirect_b", {31'd0, Redirect}, 32'd0);
        chk("b2b1_outvalid_b", {31'd0, OutValid}, 32'd0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
